hazard_unit: RTL and testbench

Parametrised pipeline hazard controller for the 5-stage RV32i core. Replaces the constant `PC_En`, `Flush_D` and `Stall_En` tie-offs with real control:
- load-use stall;
- taken-branch/jump flush;
- operand forwarding selects, or stall-only interlock when forwarding is disabled;
- multi-cycle data-memory wait.

Sits beside the stage registers in `core`, taking register addresses and control bits from each stage. Also exposes saturating stall/flush performance counters.

---
 rtl/hazard_pkg.sv | 6 +
 rtl/hazard_unit_if.sv | 19 +
 rtl/mem_wait_ctrl.sv | 32 +++
 rtl/hazard_unit.sv | 59 +++++
 tb/tb_hazard_unit.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared forward-select, result-source and memory-wait FSM encodings for hazard_unit
package hazard_pkg;
  typedef enum logic [1:0] {FWD_REG = 2'b00, FWD_W = 2'b01, FWD_M_ALU = 2'b10, FWD_M_PC4 = 2'b11} fwd_sel_t;
  localparam logic [1:0] RES_ALU = 2'b00, RES_MEM = 2'b01, RES_PC4 = 2'b10;
  typedef enum logic {IDLE, WAIT} mem_state_t;
endpackage

// File: rtl/hazard_unit_if.sv
// hazard_unit_if: stage addresses/controls in (core as master), stall/flush/forward selects and perf counters out (hazard unit as slave)
interface hazard_unit_if #(parameter int REG_ADDR_W = 5, parameter int CNT_W = 32);
  logic [REG_ADDR_W-1:0] RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W;
  logic REG_W_En_E, REG_W_En_M, REG_W_En_W, MEM_Req_M, Branch_Taken_E;
  logic [1:0] Result_Src_Sel_E, Result_Src_Sel_M;
  logic PC_En, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Flush_W;
  logic [1:0] Fwd_A_E, Fwd_B_E;
  logic [CNT_W-1:0] Stall_Cnt, Flush_Cnt;
  modport master(
    output RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W, REG_W_En_E, REG_W_En_M, REG_W_En_W,
           MEM_Req_M, Branch_Taken_E, Result_Src_Sel_E, Result_Src_Sel_M,
    input  PC_En, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Flush_W, Fwd_A_E, Fwd_B_E, Stall_Cnt, Flush_Cnt
  );
  modport slave(
    input  RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W, REG_W_En_E, REG_W_En_M, REG_W_En_W,
           MEM_Req_M, Branch_Taken_E, Result_Src_Sel_E, Result_Src_Sel_M,
    output PC_En, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Flush_W, Fwd_A_E, Fwd_B_E, Stall_Cnt, Flush_Cnt
  );
endinterface

// File: rtl/mem_wait_ctrl.sv
// mem_wait_ctrl: holds the pipe MEM_LATENCY cycles per data-memory access; ports CLK, RST, req in, mem_stall out
module mem_wait_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_LATENCY = 0
) (
  input  logic CLK,
  input  logic RST,
  input  logic req,
  output logic mem_stall
);
  localparam int CW = MEM_LATENCY > 1 ? $clog2(MEM_LATENCY) : 1;
  mem_state_t state;
  logic [CW-1:0] cnt;
  logic served, start;
  assign start = state == IDLE && req && !served && MEM_LATENCY > 0;
  assign mem_stall = state == WAIT || start;
  always_ff @(posedge CLK)
    if (RST) begin
      state <= IDLE;
      cnt <= '0;
      served <= 1'b0;
    end else if (state == WAIT) begin
      cnt <= cnt - CW'(1);
      state <= cnt == CW'(1) ? IDLE : WAIT;
      served <= cnt == CW'(1);
    end else begin
      state <= start && MEM_LATENCY > 1 ? WAIT : IDLE;
      cnt <= start ? CW'(MEM_LATENCY - 1) : cnt;
      served <= start && MEM_LATENCY == 1;
    end
endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: load-use/interlock stall, branch flush, E-stage forwarding, memory wait and saturating perf counters; ports CLK, RST, hz (slave)
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int MEM_LATENCY = 0,
  parameter int FWD_EN = 1,
  parameter int CNT_W = 32
) (
  input  logic CLK,
  input  logic RST,
  hazard_unit_if.slave hz
);
  logic mem_stall, hit_e, hit_m, hazard, ms, br, lu;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  function automatic logic hit(input logic [REG_ADDR_W-1:0] rd, input logic [REG_ADDR_W-1:0] rs);
    return rd == rs && rd != '0;
  endfunction
  function automatic fwd_sel_t fwd(input logic [REG_ADDR_W-1:0] rs, input logic wm, input logic [REG_ADDR_W-1:0] rd_m,
                                   input logic [1:0] res_m, input logic ww, input logic [REG_ADDR_W-1:0] rd_w);
    return FWD_EN == 0 ? FWD_REG :
           wm && hit(rd_m, rs) ? (res_m == RES_PC4 ? FWD_M_PC4 : FWD_M_ALU) :
           ww && hit(rd_w, rs) ? FWD_W : FWD_REG;
  endfunction
  mem_wait_ctrl #(.MEM_LATENCY(MEM_LATENCY)) u_mem_wait (
    .CLK(CLK),
    .RST(RST),
    .req(hz.MEM_Req_M),
    .mem_stall(mem_stall)
  );
  // Priority: memory wait, then branch (D is wrong-path), then load-use/interlock.
  always_comb begin
    hit_e = hz.REG_W_En_E && (hit(hz.RD_E, hz.RS1_D) || hit(hz.RD_E, hz.RS2_D));
    hit_m = hz.REG_W_En_M && (hit(hz.RD_M, hz.RS1_D) || hit(hz.RD_M, hz.RS2_D));
    hazard = FWD_EN != 0 ? hit_e && hz.Result_Src_Sel_E == RES_MEM : hit_e || hit_m;
    ms = !RST && mem_stall;
    br = !RST && !ms && hz.Branch_Taken_E;
    lu = !RST && !ms && !br && hazard;
    hz.PC_En = !(ms || lu);
    hz.Stall_D = ms || lu;
    hz.Stall_E = ms;
    hz.Stall_M = ms;
    hz.Flush_W = ms;
    hz.Flush_D = br;
    hz.Flush_E = br || lu;
    hz.Fwd_A_E = RST ? FWD_REG : fwd(hz.RS1_E, hz.REG_W_En_M, hz.RD_M, hz.Result_Src_Sel_M, hz.REG_W_En_W, hz.RD_W);
    hz.Fwd_B_E = RST ? FWD_REG : fwd(hz.RS2_E, hz.REG_W_En_M, hz.RD_M, hz.Result_Src_Sel_M, hz.REG_W_En_W, hz.RD_W);
  end
  always_ff @(posedge CLK)
    if (RST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + CNT_W'((ms || lu) && stall_cnt != '1);
      flush_cnt <= flush_cnt + CNT_W'(br && flush_cnt != '1);
    end
  assign hz.Stall_Cnt = stall_cnt;
  assign hz.Flush_Cnt = flush_cnt;
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: scoreboard bench for a forwarding/3-cycle-memory instance and an interlock/no-wait instance
module tb_hazard_unit;
  typedef struct packed {
    logic rst;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e;
    logic we;
    logic [1:0] res_e;
    logic [4:0] rd_m;
    logic wm;
    logic [1:0] res_m;
    logic req;
    logic [4:0] rd_w;
    logic ww, br;
  } in_t;
  typedef struct packed {
    logic pc, sd, se, sm, fd, fe, fw;
    logic [1:0] fa, fb;
    logic [3:0] sc, fc;
  } out_t;
  typedef out_t [1:0] pair_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  in_t cur;
  out_t act [2];
  pair_t sb [$];
  int checks = 0, errors = 0;
  int rem [2], sc [2], fc [2];
  bit rel [2];
  out_t last [2];
  hazard_unit_if #(.REG_ADDR_W(5), .CNT_W(4)) ifs [2] ();
  genvar g;
  for (g = 0; g < 2; g++) begin : gen_dut
    assign ifs[g].RS1_D = cur.rs1_d;
    assign ifs[g].RS2_D = cur.rs2_d;
    assign ifs[g].RS1_E = cur.rs1_e;
    assign ifs[g].RS2_E = cur.rs2_e;
    assign ifs[g].RD_E = cur.rd_e;
    assign ifs[g].REG_W_En_E = cur.we;
    assign ifs[g].Result_Src_Sel_E = cur.res_e;
    assign ifs[g].RD_M = cur.rd_m;
    assign ifs[g].REG_W_En_M = cur.wm;
    assign ifs[g].Result_Src_Sel_M = cur.res_m;
    assign ifs[g].MEM_Req_M = cur.req;
    assign ifs[g].RD_W = cur.rd_w;
    assign ifs[g].REG_W_En_W = cur.ww;
    assign ifs[g].Branch_Taken_E = cur.br;
    assign act[g] = {ifs[g].PC_En, ifs[g].Stall_D, ifs[g].Stall_E, ifs[g].Stall_M, ifs[g].Flush_D, ifs[g].Flush_E,
                     ifs[g].Flush_W, ifs[g].Fwd_A_E, ifs[g].Fwd_B_E, ifs[g].Stall_Cnt, ifs[g].Flush_Cnt};
    hazard_unit #(.REG_ADDR_W(5), .MEM_LATENCY(g == 0 ? 3 : 0), .FWD_EN(g == 0 ? 1 : 0), .CNT_W(4)) u_dut (
      .CLK(clk),
      .RST(cur.rst),
      .hz(ifs[g])
    );
  end
  function automatic int lat(int k);
    return k == 0 ? 3 : 0;
  endfunction
  function automatic bit m(logic [4:0] rd, logic [4:0] rs);
    return rd != 0 && rd == rs;
  endfunction
  function automatic logic [1:0] fsel(bit en, logic [4:0] rs, in_t v);
    if (!en || rs == 0) return 2'd0;
    if (v.wm && v.rd_m == rs) return v.res_m == 2'd2 ? 2'd3 : 2'd2;
    if (v.ww && v.rd_w == rs) return 2'd1;
    return 2'd0;
  endfunction
  function automatic out_t model(int k, in_t v);
    out_t o;
    bit en, ms, ld, hz;
    en = k == 0;
    o = '0;
    ms = rem[k] > 0 || (v.req && !rel[k] && lat(k) > 0);
    ld = v.we && v.res_e == 2'd1 && (m(v.rd_e, v.rs1_d) || m(v.rd_e, v.rs2_d));
    hz = en ? ld : (v.we && (m(v.rd_e, v.rs1_d) || m(v.rd_e, v.rs2_d))) || (v.wm && (m(v.rd_m, v.rs1_d) || m(v.rd_m, v.rs2_d)));
    if (v.rst) o.pc = 1;
    else if (ms) begin o.sd = 1; o.se = 1; o.sm = 1; o.fw = 1; end
    else if (v.br) begin o.pc = 1; o.fd = 1; o.fe = 1; end
    else if (hz) begin o.sd = 1; o.fe = 1; end
    else o.pc = 1;
    o.fa = v.rst ? 2'd0 : fsel(en, v.rs1_e, v);
    o.fb = v.rst ? 2'd0 : fsel(en, v.rs2_e, v);
    o.sc = 4'(sc[k]);
    o.fc = 4'(fc[k]);
    return o;
  endfunction
  task automatic tick();
    for (int k = 0; k < 2; k++) begin
      if (cur.rst) begin
        rem[k] = 0; rel[k] = 0; sc[k] = 0; fc[k] = 0;
      end else begin
        if (!last[k].pc && sc[k] < 15) sc[k]++;
        if (last[k].fd && fc[k] < 15) fc[k]++;
        if (rem[k] > 0) begin
          rem[k]--;
          rel[k] = rem[k] == 0;
        end else if (cur.req && !rel[k] && lat(k) > 0) begin
          rem[k] = lat(k) - 1;
          rel[k] = rem[k] == 0;
        end else rel[k] = 0;
      end
    end
  endtask
  task automatic step(input in_t v);
    pair_t p;
    @(posedge clk);
    #1;
    tick();
    cur = v;
    for (int k = 0; k < 2; k++) begin
      p[k] = model(k, v);
      last[k] = p[k];
    end
    sb.push_back(p);
  endtask
  function automatic in_t rnd();
    in_t v;
    v.rst = $urandom_range(0, 63) == 0;
    v.rs1_d = 5'($urandom_range(0, 3));
    v.rs2_d = 5'($urandom_range(0, 3));
    v.rs1_e = 5'($urandom_range(0, 3));
    v.rs2_e = 5'($urandom_range(0, 3));
    v.rd_e = 5'($urandom_range(0, 3));
    v.rd_m = 5'($urandom_range(0, 3));
    v.rd_w = 5'($urandom_range(0, 3));
    v.we = 1'($urandom_range(0, 1));
    v.wm = 1'($urandom_range(0, 1));
    v.ww = 1'($urandom_range(0, 1));
    v.res_e = 2'($urandom_range(0, 2));
    v.res_m = 2'($urandom_range(0, 2));
    v.req = $urandom_range(0, 2) == 0;
    v.br = $urandom_range(0, 7) == 0;
    return v;
  endfunction
  task automatic cmp(string n, int k, logic [3:0] a, logic [3:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s dut%0d got %0h expected %0h at %0t", n, k, a, e, $time);
    end
  endtask
  initial begin
    pair_t p;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        p = sb.pop_front();
        for (int k = 0; k < 2; k++) begin
          cmp("PC_En", k, 4'(act[k].pc), 4'(p[k].pc));
          cmp("Stall_D", k, 4'(act[k].sd), 4'(p[k].sd));
          cmp("Stall_E", k, 4'(act[k].se), 4'(p[k].se));
          cmp("Stall_M", k, 4'(act[k].sm), 4'(p[k].sm));
          cmp("Flush_D", k, 4'(act[k].fd), 4'(p[k].fd));
          cmp("Flush_E", k, 4'(act[k].fe), 4'(p[k].fe));
          cmp("Flush_W", k, 4'(act[k].fw), 4'(p[k].fw));
          cmp("Fwd_A_E", k, 4'(act[k].fa), 4'(p[k].fa));
          cmp("Fwd_B_E", k, 4'(act[k].fb), 4'(p[k].fb));
          cmp("Stall_Cnt", k, act[k].sc, p[k].sc);
          cmp("Flush_Cnt", k, act[k].fc, p[k].fc);
        end
      end
    end
  end
  initial begin
    in_t v;
    cur = '0;
    cur.rst = 1;
    for (int k = 0; k < 2; k++) begin
      rem[k] = 0; rel[k] = 0; sc[k] = 0; fc[k] = 0; last[k] = '0;
    end
    v = '0; v.rst = 1;
    step(v); step(v);
    v = '0; v.wm = 1; v.rd_m = 5; v.rs1_e = 5;
    step(v);
    v.res_m = 2;
    step(v);
    v = '0; v.ww = 1; v.rd_w = 5; v.rs1_e = 5; v.rs2_e = 5;
    step(v);
    v = '0; v.wm = 1; v.ww = 1;
    step(v);
    v = '0; v.we = 1; v.res_e = 1; v.rd_e = 6; v.rs2_d = 6;
    step(v);
    v = '0; v.wm = 1; v.rd_m = 6; v.res_m = 1; v.rs2_e = 6; v.req = 1;
    repeat (4) step(v);
    v = '0; v.we = 1; v.rd_e = 7; v.rs1_d = 7;
    step(v);
    v = '0; v.wm = 1; v.rd_m = 7; v.rs1_d = 7;
    step(v);
    v = '0; v.ww = 1; v.rd_w = 7; v.rs1_d = 7;
    step(v);
    v = '0; v.we = 1; v.res_e = 1; v.rd_e = 6; v.rs1_d = 6; v.br = 1;
    step(v);
    v = '0; v.req = 1;
    repeat (8) step(v);
    v.br = 1;
    repeat (4) step(v);
    v = '0; v.req = 1;
    step(v);
    v.rst = 1;
    step(v);
    v.rst = 0;
    repeat (4) step(v);
    v = '0; v.we = 1; v.res_e = 1; v.rd_e = 3; v.rs1_d = 3;
    repeat (20) step(v);
    v.br = 1;
    repeat (20) step(v);
    repeat (1500) step(rnd());
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain %0d entries left expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
